memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memstage_pkg.sv | 23 ++
 rtl/ex_mem_reg.sv | 24 ++
 rtl/memory_stage.sv | 146 ++++++++++++++
 tb/tb_memory_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memstage_pkg.sv
// Shared types for the memory pipeline stage.
// Build option: MISALIGN_TRAP_EN enables the misaligned-access trap.
package memstage_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RD
   } state_t;

   typedef struct packed {
      logic              branch;
      logic              mem_read;
      logic              mem_write;
      logic              zero;
      logic [DATA_W-1:0] pc_branch;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] write_data;
   } ex_mem_t;

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: loads when not held, keeps payload on bubbles.
module ex_mem_reg
   import memstage_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    hold,
   input  logic    valid_d,
   input  ex_mem_t d,
   output logic    valid_q,
   output ex_mem_t q
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         q       <= '0;
      end else if (!hold) begin
         valid_q <= valid_d;
         if (valid_d) q <= d;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: EX/MEM register, data-memory handshake FSM, MEM/WB outputs.
// Build option: MISALIGN_TRAP_EN adds misalign_W and the alignment trap.
module memory_stage
   import memstage_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_E,
   input  logic              Branch_E,
   input  logic              MemRead_E,
   input  logic              MemWrite_E,
   input  logic [DATA_W-1:0] PCBranch_E,
   input  logic [DATA_W-1:0] aluResult_E,
   input  logic [DATA_W-1:0] writeData_E,
   input  logic              zero_E,
   output logic              stall_M,
   output logic              PCSrc_M,
   output logic [DATA_W-1:0] PCBranch_M,
   output logic              dm_req,
   output logic              dm_we,
   output logic [DATA_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_gnt,
   input  logic              dm_rvalid,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              valid_W,
   output logic [DATA_W-1:0] readData_W,
   output logic [DATA_W-1:0] aluResult_W
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              misalign_W
`endif
);

   ex_mem_t e_bus;
   ex_mem_t m;
   logic    valid_M;
   state_t  state;
   state_t  state_nx;
   logic    mem_op;
   logic    mis;
   logic    complete;
   logic    rd_done;

   assign e_bus = '{
      branch:     Branch_E,
      mem_read:   MemRead_E,
      mem_write:  MemWrite_E,
      zero:       zero_E,
      pc_branch:  PCBranch_E,
      alu_result: aluResult_E,
      write_data: writeData_E
   };

   ex_mem_reg u_ex_mem (
      .clk     (clk),
      .reset   (reset),
      .hold    (stall_M),
      .valid_d (valid_E),
      .d       (e_bus),
      .valid_q (valid_M),
      .q       (m)
   );

   assign mem_op = valid_M & (m.mem_read | m.mem_write);

`ifdef MISALIGN_TRAP_EN
   assign mis = mem_op & (m.alu_result[2:0] != 3'b000);
`else
   assign mis = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      complete = 1'b0;
      rd_done  = 1'b0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      unique case (state)
         IDLE: begin
            if (mem_op && !mis) state_nx = REQ;
            else if (valid_M)   complete = 1'b1;
         end
         REQ: begin
            dm_req   = 1'b1;
            dm_we    = m.mem_write;
            dm_addr  = m.alu_result;
            dm_wdata = m.write_data;
            if (dm_gnt) begin
               if (m.mem_write) begin
                  complete = 1'b1;
                  state_nx = IDLE;
               end else if (dm_rvalid) begin
                  complete = 1'b1;
                  rd_done  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  state_nx = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (dm_rvalid) begin
               complete = 1'b1;
               rd_done  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Non-memory ops and trapped ops complete in IDLE, so they never stall.
   assign stall_M    = mem_op & ~complete;
   assign PCSrc_M    = valid_M & m.branch & m.zero;
   assign PCBranch_M = m.pc_branch;

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_W     <= 1'b0;
         readData_W  <= '0;
         aluResult_W <= '0;
      end else begin
         valid_W <= complete;
         if (complete) begin
            aluResult_W <= m.alu_result;
            readData_W  <= rd_done ? dm_rdata : '0;
         end
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!reset) misalign_W <= 1'b0;
      else        misalign_W <= complete & mis;
   end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed table, corner sequences, random traffic.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_E;
   logic        Branch_E;
   logic        MemRead_E;
   logic        MemWrite_E;
   logic [63:0] PCBranch_E;
   logic [63:0] aluResult_E;
   logic [63:0] writeData_E;
   logic        zero_E;
   logic        stall_M;
   logic        PCSrc_M;
   logic [63:0] PCBranch_M;
   logic        dm_req;
   logic        dm_we;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [63:0] dm_rdata;
   logic        valid_W;
   logic [63:0] readData_W;
   logic [63:0] aluResult_W;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_W;
`endif

   memory_stage dut (
      .clk         (clk),
      .reset       (reset),
      .valid_E     (valid_E),
      .Branch_E    (Branch_E),
      .MemRead_E   (MemRead_E),
      .MemWrite_E  (MemWrite_E),
      .PCBranch_E  (PCBranch_E),
      .aluResult_E (aluResult_E),
      .writeData_E (writeData_E),
      .zero_E      (zero_E),
      .stall_M     (stall_M),
      .PCSrc_M     (PCSrc_M),
      .PCBranch_M  (PCBranch_M),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_gnt      (dm_gnt),
      .dm_rvalid   (dm_rvalid),
      .dm_rdata    (dm_rdata),
      .valid_W     (valid_W),
      .readData_W  (readData_W),
      .aluResult_W (aluResult_W)
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign_W  (misalign_W)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          kind;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          gl;
      int          rl;
      logic        br;
      logic        zr;
      logic [63:0] pcb;
      int          lat;
      logic [63:0] exp_rd;
      logic        exp_pc;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive_e(input int kind, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic br,
                          input logic zr, input logic [63:0] pcb);
      valid_E     = 1'b1;
      Branch_E    = br;
      MemRead_E   = (kind == 1);
      MemWrite_E  = (kind == 2);
      zero_E      = zr;
      PCBranch_E  = pcb;
      aluResult_E = addr;
      writeData_E = wdata;
   endtask

   // Transaction-level reference: latency to completion and W payload.
   function automatic void model(input int kind, input logic [63:0] addr,
                                 input int gl, input int rl,
                                 input logic br, input logic zr,
                                 input logic [63:0] rdata,
                                 output int lat, output logic [63:0] rd,
                                 output logic pc, output logic mis);
      mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (kind != 0) && (addr[2:0] != 3'b000);
`endif
      pc = br & zr;
      if (kind == 0 || mis) begin
         lat = 0;
         rd  = 64'h0;
      end else if (kind == 2) begin
         lat = 1 + gl;
         rd  = 64'h0;
      end else begin
         lat = 1 + gl + rl;
         rd  = rdata;
      end
   endfunction

   task automatic run_txn(input string nm, input vec_t v);
      bit          memop;
      bit          rv_hit;
      logic [63:0] noise;
      @(negedge clk);
      drive_e(v.kind, v.addr, v.wdata, v.br, v.zr, v.pcb);
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      memop = (v.kind != 0) && !v.exp_mis;
      for (int c = 0; c <= v.lat + 1; c++) begin
         @(negedge clk);
         valid_E = 1'b0;
         rv_hit  = (v.kind == 1) && memop && (c == 1 + v.gl + v.rl);
         dm_gnt  = (memop && c == 1 + v.gl)
                || (c == 0 && $urandom_range(1) == 1)
                || (v.kind == 1 && memop && c > 1 + v.gl && c <= v.lat
                    && $urandom_range(1) == 1);
         dm_rvalid = rv_hit || (c == 0 && $urandom_range(1) == 1);
         noise     = {$urandom, $urandom};
         dm_rdata  = rv_hit ? v.rdata : noise;
         #1;
         chk({nm, " stall"}, stall_M, 64'(c < v.lat));
         chk({nm, " req"}, dm_req,
             64'(memop && c >= 1 && c <= 1 + v.gl));
         if (memop && c >= 1 && c <= 1 + v.gl) begin
            chk({nm, " addr"}, dm_addr, v.addr);
            chk({nm, " we"}, dm_we, 64'(v.kind == 2));
            if (v.kind == 2) chk({nm, " wdata"}, dm_wdata, v.wdata);
         end
         chk({nm, " pcsrc"}, PCSrc_M, 64'((c <= v.lat) && v.exp_pc));
         if (c == 0) chk({nm, " pcbranch"}, PCBranch_M, v.pcb);
         if (c <= v.lat) begin
            chk({nm, " vw_early"}, valid_W, 64'h0);
         end else begin
            chk({nm, " valid_W"}, valid_W, 64'h1);
            chk({nm, " aluW"}, aluResult_W, v.addr);
            chk({nm, " rdW"}, readData_W, v.exp_rd);
`ifdef MISALIGN_TRAP_EN
            chk({nm, " misW"}, misalign_W, 64'(v.exp_mis));
`endif
         end
      end
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
   endtask

   initial begin
      vec_t rv;
      reset     = 1'b0;
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      dm_rdata  = 64'h0;
      drive_e(1, 64'h88, 64'h99, 1'b1, 1'b1, 64'h500);
      repeat (3) @(negedge clk);
      #1;
      chk("rst stall", stall_M, 64'h0);
      chk("rst req", dm_req, 64'h0);
      chk("rst we", dm_we, 64'h0);
      chk("rst addr", dm_addr, 64'h0);
      chk("rst wdata", dm_wdata, 64'h0);
      chk("rst pcsrc", PCSrc_M, 64'h0);
      chk("rst pcb", PCBranch_M, 64'h0);
      chk("rst vw", valid_W, 64'h0);
      chk("rst aluW", aluResult_W, 64'h0);
      chk("rst rdW", readData_W, 64'h0);
      @(negedge clk);
      valid_E = 1'b0;
      reset   = 1'b1;

      vecs[0] = '{0, 64'h10, 64'h0, 64'h0, 0, 0, 1'b0, 1'b0, 64'h0,
                  0, 64'h0, 1'b0, 1'b0};
      vecs[1] = '{1, 64'h40, 64'h0, 64'hDEADBEEF, 2, 3, 1'b0, 1'b0,
                  64'h0, 6, 64'hDEADBEEF, 1'b0, 1'b0};
      vecs[2] = '{2, 64'h80, 64'h1234, 64'h0, 0, 0, 1'b0, 1'b0, 64'h0,
                  1, 64'h0, 1'b0, 1'b0};
      vecs[3] = '{0, 64'h18, 64'h0, 64'h0, 0, 0, 1'b1, 1'b1, 64'h200,
                  0, 64'h0, 1'b1, 1'b0};
      vecs[4] = '{0, 64'h20, 64'h0, 64'h0, 0, 0, 1'b1, 1'b0, 64'h300,
                  0, 64'h0, 1'b0, 1'b0};
      vecs[5] = '{1, 64'h48, 64'h0, 64'hCAFEF00D12345678, 0, 0, 1'b0,
                  1'b0, 64'h0, 1, 64'hCAFEF00D12345678, 1'b0, 1'b0};
`ifdef MISALIGN_TRAP_EN
      vecs[6] = '{1, 64'h43, 64'h0, 64'h77, 0, 1, 1'b0, 1'b0, 64'h0,
                  0, 64'h0, 1'b0, 1'b1};
`else
      vecs[6] = '{1, 64'h43, 64'h0, 64'h77, 0, 1, 1'b0, 1'b0, 64'h0,
                  2, 64'h77, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

      // Back-to-back writes: B captured in the cycle A's stall drops.
      @(negedge clk);
      drive_e(2, 64'h100, 64'hA, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      drive_e(2, 64'h108, 64'hB, 1'b0, 1'b0, 64'h0);
      #1;
      chk("b2b c0 stall", stall_M, 64'h1);
      chk("b2b c0 req", dm_req, 64'h0);
      @(negedge clk);
      dm_gnt = 1'b1;
      #1;
      chk("b2b c1 req", dm_req, 64'h1);
      chk("b2b c1 addr", dm_addr, 64'h100);
      chk("b2b c1 stall", stall_M, 64'h0);
      @(negedge clk);
      valid_E = 1'b0;
      dm_gnt  = 1'b0;
      #1;
      chk("b2b c2 vw", valid_W, 64'h1);
      chk("b2b c2 aluW", aluResult_W, 64'h100);
      chk("b2b c2 stall", stall_M, 64'h1);
      chk("b2b c2 req", dm_req, 64'h0);
      @(negedge clk);
      dm_gnt = 1'b1;
      #1;
      chk("b2b c3 addr", dm_addr, 64'h108);
      chk("b2b c3 wdata", dm_wdata, 64'hB);
      chk("b2b c3 vw", valid_W, 64'h0);
      @(negedge clk);
      dm_gnt = 1'b0;
      #1;
      chk("b2b c4 vw", valid_W, 64'h1);
      chk("b2b c4 aluW", aluResult_W, 64'h108);

      // Reset while waiting for read data, then a late rvalid.
      @(negedge clk);
      drive_e(1, 64'h40, 64'h0, 1'b1, 1'b1, 64'h600);
      @(negedge clk);
      valid_E = 1'b0;
      @(negedge clk);
      dm_gnt = 1'b1;
      @(negedge clk);
      dm_gnt = 1'b0;
      reset  = 1'b0;
      #1;
      chk("rmid wait req", dm_req, 64'h0);
      chk("rmid wait stall", stall_M, 64'h1);
      @(negedge clk);
      reset     = 1'b1;
      dm_rvalid = 1'b1;
      dm_rdata  = 64'h55;
      #1;
      chk("rmid stall", stall_M, 64'h0);
      chk("rmid req", dm_req, 64'h0);
      chk("rmid pcsrc", PCSrc_M, 64'h0);
      chk("rmid pcb", PCBranch_M, 64'h0);
      chk("rmid aluW", aluResult_W, 64'h0);
      @(negedge clk);
      dm_rvalid = 1'b0;
      #1;
      chk("rmid vw", valid_W, 64'h0);
      chk("rmid rdW", readData_W, 64'h0);
      @(negedge clk);
      #1;
      chk("rmid vw2", valid_W, 64'h0);

      for (int i = 0; i < 40; i++) begin
         rv.kind  = int'($urandom_range(2));
         rv.addr  = {$urandom, $urandom};
         if ($urandom_range(3) != 0) rv.addr[2:0] = 3'b000;
         rv.wdata = {$urandom, $urandom};
         rv.rdata = {$urandom, $urandom};
         rv.gl    = int'($urandom_range(3));
         rv.rl    = int'($urandom_range(3));
         rv.br    = 1'($urandom_range(1));
         rv.zr    = 1'($urandom_range(1));
         rv.pcb   = {$urandom, $urandom};
         model(rv.kind, rv.addr, rv.gl, rv.rl, rv.br, rv.zr, rv.rdata,
               rv.lat, rv.exp_rd, rv.exp_pc, rv.exp_mis);
         run_txn($sformatf("rnd%0d", i), rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
